// File: rtl/lcdc_pkg.sv
// lcdc_pkg: shared VRAM geometry, clear-FSM states and arbiter owner encoding for the S1D13700 LCDC
package lcdc_pkg;
  localparam int LCDC_AW = 13;
  localparam int LCDC_DW = 8;
  localparam logic [12:0] LCDC_VRAM_LAST = 13'h12bf;
  typedef enum logic [1:0] {CLR_IDLE, CLR_FILL, CLR_DONE} clr_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_TFT, OWN_CPU, OWN_CLR} owner_t;
endpackage

// File: rtl/vram_clr_fsm.sv
// vram_clr_fsm: VRAM fill engine with address counter, fill latch and CPU-starvation wait counter
module vram_clr_fsm
  import lcdc_pkg::*;
#(
  parameter int AW = LCDC_AW,
  parameter int DW = LCDC_DW,
  parameter logic [AW-1:0] VRAM_LAST = AW'(LCDC_VRAM_LAST),
  parameter int CLR_MAX_WAIT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_data,
  input  logic          clr_gnt,
  input  logic          cpu_gnt,
  output logic          clr_req,
  output logic          clr_force,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] clr_addr,
  output logic [DW-1:0] clr_wdata
);
  clr_state_t state, state_nx;
  logic [4:0] wait_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= CLR_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      CLR_IDLE: state_nx = clr_start ? CLR_FILL : CLR_IDLE;
      CLR_FILL: state_nx = (clr_gnt && clr_addr == VRAM_LAST) ? CLR_DONE : CLR_FILL;
      default:  state_nx = CLR_IDLE;
    endcase
  end
  always_comb begin
    clr_req   = state == CLR_FILL;
    clr_force = clr_req && wait_cnt == 5'(CLR_MAX_WAIT);
    clr_busy  = state != CLR_IDLE;
    clr_done  = state == CLR_DONE;
  end
  // wait_cnt only advances when the CPU, not the TFT, takes the slot from a pending write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clr_addr  <= '0;
      clr_wdata <= '0;
      wait_cnt  <= '0;
    end else if (state == CLR_IDLE && clr_start) begin
      clr_addr  <= '0;
      clr_wdata <= clr_data;
      wait_cnt  <= '0;
    end else if (clr_gnt) begin
      clr_addr <= clr_addr + 1'b1;
      wait_cnt <= '0;
    end else if (clr_req && cpu_gnt && wait_cnt != '1) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
endmodule

// File: rtl/vram_arb.sv
// vram_arb: single-port VRAM arbiter (TFT > forced clear > CPU > clear) with CPU read-return routing
module vram_arb
  import lcdc_pkg::*;
#(
  parameter int AW = LCDC_AW,
  parameter int DW = LCDC_DW,
  parameter logic [AW-1:0] VRAM_LAST = AW'(LCDC_VRAM_LAST),
  parameter int CLR_MAX_WAIT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tft_rdreq,
  input  logic [AW-1:0] tft_raddr,
  output logic          tft_rdack,
  output logic [DW-1:0] tft_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_rvld,
  output logic [DW-1:0] cpu_rdata,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_data,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  owner_t own;
  logic clr_req, clr_force, clr_gnt, cpu_gnt, cpu_ok, rd_own, rd_oob;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] clr_wdata;
  vram_clr_fsm #(
    .AW(AW), .DW(DW), .VRAM_LAST(VRAM_LAST), .CLR_MAX_WAIT(CLR_MAX_WAIT)
  ) u_clr (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_data(clr_data),
    .clr_gnt(clr_gnt), .cpu_gnt(cpu_gnt), .clr_req(clr_req), .clr_force(clr_force),
    .clr_busy(clr_busy), .clr_done(clr_done), .clr_addr(clr_addr), .clr_wdata(clr_wdata)
  );
  // grant is purely combinational so a one-cycle tft_rdreq is always served
  always_comb begin
    own = tft_rdreq ? OWN_TFT : clr_force ? OWN_CLR : cpu_req ? OWN_CPU : clr_req ? OWN_CLR : OWN_NONE;
    clr_gnt   = own == OWN_CLR;
    cpu_gnt   = own == OWN_CPU;
    cpu_ok    = cpu_addr <= VRAM_LAST;
    tft_rdack = tft_rdreq;
    cpu_ack   = cpu_gnt;
    ram_cs    = own == OWN_TFT || clr_gnt || (cpu_gnt && cpu_ok);
    ram_we    = clr_gnt || (cpu_gnt && cpu_ok && cpu_we);
    ram_addr  = own == OWN_TFT ? tft_raddr : clr_gnt ? clr_addr : cpu_gnt ? cpu_addr : '0;
    ram_wdata = clr_gnt ? clr_wdata : (cpu_gnt && cpu_we) ? cpu_wdata : '0;
    tft_rdata = ram_rdata;
    cpu_rvld  = rd_own;
    cpu_rdata = (rd_own && !rd_oob) ? ram_rdata : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_own <= 1'b0;
      rd_oob <= 1'b0;
    end else begin
      rd_own <= cpu_gnt && !cpu_we;
      rd_oob <= !cpu_ok;
    end
endmodule

// File: doc/vram_arb.md
# vram_arb

Single-port display-RAM arbiter and clear engine for the S1D13700 LCD controller. It shares one 8-bit synchronous VRAM between three requesters:
- the TFT timing generator's read port, which always wins;
- the host CPU access port;
- an internal clear engine that fills VRAM with a constant.

It sits between the timing generator/host interface and the VRAM macro. It issues at most one RAM access per clock.

## Interface
Parameters:
- AW, 13, VRAM address width
- DW, 8, VRAM data width
- VRAM_LAST, 13'h12bf, last valid VRAM address (4800 bytes)
- CLR_MAX_WAIT, 16, cycles a pending clear write may be denied by the CPU before it is forced

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - clk in 1 clock
  - rst in 1 reset
- TFT read port:
  - tft_rdreq in 1 TFT read request, single-cycle pulse
  - tft_raddr in AW TFT read address
  - tft_rdack out 1 TFT grant, same cycle as tft_rdreq
  - tft_rdata out DW read data, equals ram_rdata
- CPU port:
  - cpu_req in 1 CPU request, held until cpu_ack
  - cpu_we in 1 1 = write, 0 = read
  - cpu_addr in AW CPU address
  - cpu_wdata in DW CPU write data
  - cpu_ack out 1 CPU grant pulse
  - cpu_rvld out 1 CPU read data valid pulse
  - cpu_rdata out DW CPU read data, valid when cpu_rvld = 1
- Clear engine:
  - clr_start in 1 start-clear pulse
  - clr_data in DW fill byte, sampled at start
  - clr_busy out 1 clear in progress
  - clr_done out 1 clear-complete pulse
- VRAM:
  - ram_cs out 1 RAM select
  - ram_we out 1 RAM write enable
  - ram_addr out AW RAM address
  - ram_wdata out DW RAM write data
  - ram_rdata in DW RAM read data, valid one cycle after a read select

## Operation
- Fixed priority per cycle: TFT > forced clear > CPU > clear.
  - The grant is combinational, so a single-cycle tft_rdreq is never lost.
  - tft_rdack = tft_rdreq.
- Forced clear: a clear write is pending and the wait counter equals CLR_MAX_WAIT. The counter:
  - is 5 bits, saturating;
  - counts each cycle a pending clear write is denied by a CPU grant;
  - clears on every clear grant.
- CPU addresses above VRAM_LAST:
  - still acked;
  - ram_cs stays 0, so writes are dropped;
  - reads return cpu_rvld with cpu_rdata = 8'h00.
- Read return: a one-bit registered owner flag marks a CPU read grant.
  - In the next cycle it drives cpu_rvld = 1 and routes ram_rdata to cpu_rdata.
  - Otherwise cpu_rdata = 0.
- Clear FSM states: IDLE, FILL, DONE.
  - IDLE: clr_start latches clr_data, sets the address counter to 0, goes to FILL.
  - FILL: one write per clear grant. When the granted address equals VRAM_LAST, go to DONE.
  - DONE: clr_done = 1 for one cycle, then IDLE.
- clr_start in FILL or DONE is ignored.
- clr_busy = 1 in FILL and DONE.
- The TFT port is not blocked during a clear. It reads whatever VRAM holds.
- Reset at any time returns the FSM to IDLE. A partial clear is not resumed.

## Timing
- Reset values:
  - tft_rdack, cpu_ack, cpu_rvld, clr_busy, clr_done, ram_cs, ram_we = 0
  - ram_addr, ram_wdata, cpu_rdata = 0
  - the RAM port outputs are combinational from idle requests, so they are also 0 in reset
- Grant cycle N: ram_cs/ram_we/ram_addr/ram_wdata are driven in cycle N and sampled by the RAM at the end of N.
- Read latency: read data is valid in cycle N+1. The TFT latches it there; cpu_rvld = 1 in N+1.
- CPU throughput: with no contention, a held cpu_req gets one ack per cycle. Back-to-back accesses are allowed.
- TFT collisions:
  - tft_rdreq coinciding with cpu_req: cpu_ack = 0 and the CPU retries next cycle.
  - tft_rdreq coinciding with a forced clear: the TFT wins and the wait counter does not reset.
- Full clear duration: at least VRAM_LAST+1 = 4800 cycles with no other traffic. clr_done fires in cycle 4801 after the first FILL cycle.

## Structure
- Shared package lcdc_pkg holds:
  - VRAM_LAST and the AW/DW defaults;
  - the clear-FSM state enum;
  - the owner encoding: NONE, TFT, CPU, CLR.
- One sub-module is natural: vram_clr_fsm, which holds the state, the address counter, the fill latch and the wait counter.
- Arbitration and read routing stay in the top level.

## Test plan
- TFT read at 13'h0010 on an idle bus:
  - tft_rdack = 1 in the same cycle;
  - ram_addr = 13'h0010, ram_we = 0;
  - the preloaded byte 8'h5a appears on tft_rdata the next cycle.
- CPU write 8'hA5 to 13'h0100, then a read of the same address:
  - two acks;
  - cpu_rvld = 1 one cycle after the read ack, with cpu_rdata = 8'hA5.
- Collision: tft_rdreq and cpu_req in the same cycle:
  - TFT is granted and cpu_ack = 0;
  - the CPU is acked in the next cycle with no data loss.
- Clear with clr_data = 8'hFF and no traffic:
  - clr_busy rises the cycle after clr_start;
  - addresses 0 through 13'h12bf are written;
  - one clr_done pulse follows;
  - all bytes read back 8'hFF.
- Starvation:
  - during a clear with cpu_req held high, a clear write is forced exactly once every CLR_MAX_WAIT+1 cycles;
  - the clear completes.
- Boundary cases:
  - a CPU write to 13'h12c0 is acked with ram_cs = 0;
  - a read there returns 8'h00;
  - asserting rst mid-clear returns all outputs to 0, and a new clr_start restarts at address 0.
